// File: rtl/modport_if.sv
// Memory-access bus interface unit for one CPU pipeline stage: zero-wait SPM
// accesses locally, everything else through a request/grant/strobe/ready bus cycle.
module modport_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SIDX_W  = 3,
    parameter int unsigned SPM_IDX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_as_n,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_n,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              bus_req_n,
    input  logic              bus_grnt_n,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_n,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_n
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic              req_n_q,   req_n_d;
    logic              as_n_q,    as_n_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              rw_q,      rw_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] rd_buf_q,  rd_buf_d;
    logic [SIDX_W-1:0] sidx_s;
    logic              valid_s;
    logic              is_spm_s;

    assign sidx_s      = cpu_addr[ADDR_W-1 -: SIDX_W];
    assign valid_s     = (cpu_as_n == 1'b0) && (flush == 1'b0);
    assign is_spm_s    = (sidx_s == SIDX_W'(SPM_IDX));
    assign spm_addr    = cpu_addr;
    assign spm_rw      = cpu_rw;
    assign spm_wr_data = cpu_wr_data;
    assign bus_req_n   = req_n_q;
    assign bus_as_n    = as_n_q;
    assign bus_addr    = addr_q;
    assign bus_rw      = rw_q;
    assign bus_wr_data = wdata_q;

    // CPU-facing combinational outputs: SPM data passes through in the same cycle
    always_comb begin
        cpu_rd_data = {DATA_W{1'b0}};
        spm_as_n    = 1'b1;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_s && is_spm_s && !stall) begin
                    spm_as_n    = 1'b0;
                    cpu_rd_data = cpu_rw ? spm_rd_data : {DATA_W{1'b0}};
                end else if (valid_s && !is_spm_s) begin
                    busy = 1'b1;
                end else begin
                    busy = 1'b0;
                end
            end
            ST_REQ: busy = 1'b1;
            ST_ACCESS: begin
                if (!bus_rdy_n) begin
                    busy        = 1'b0;
                    cpu_rd_data = cpu_rw ? bus_rd_data : {DATA_W{1'b0}};
                end else begin
                    busy = 1'b1;
                end
            end
            ST_STALL: begin
                busy        = 1'b0;
                cpu_rd_data = cpu_rw ? rd_buf_q : {DATA_W{1'b0}};
            end
            default: begin
                cpu_rd_data = {DATA_W{1'b0}};
                spm_as_n    = 1'b1;
                busy        = 1'b0;
            end
        endcase
    end

    // Bus handshake sequencing; flush only matters before the request is issued
    always_comb begin
        state_d  = state_q;
        req_n_d  = req_n_q;
        as_n_d   = as_n_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rd_buf_d = rd_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_s && !is_spm_s) begin
                    state_d = ST_REQ;
                    req_n_d = 1'b0;
                    addr_d  = cpu_addr;
                    rw_d    = cpu_rw;
                    wdata_d = cpu_wr_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!bus_grnt_n) begin
                    state_d = ST_ACCESS;
                    as_n_d  = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ACCESS: begin
                as_n_d = 1'b1;
                if (!bus_rdy_n) begin
                    req_n_d  = 1'b1;
                    addr_d   = {ADDR_W{1'b0}};
                    rw_d     = 1'b1;
                    wdata_d  = {DATA_W{1'b0}};
                    rd_buf_d = rw_q ? bus_rd_data : rd_buf_q;
                    state_d  = stall ? ST_STALL : ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and bus-side registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            req_n_q  <= 1'b1;
            as_n_q   <= 1'b1;
            addr_q   <= {ADDR_W{1'b0}};
            rw_q     <= 1'b1;
            wdata_q  <= {DATA_W{1'b0}};
            rd_buf_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            req_n_q  <= req_n_d;
            as_n_q   <= as_n_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            rd_buf_q <= rd_buf_d;
        end
    end

endmodule

// File: tb/tb_modport_if.sv
// Directed bench for modport_if: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_modport_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, busy;
    logic [29:0] cpu_addr;
    logic        cpu_as_n, cpu_rw;
    logic [31:0] cpu_wr_data, cpu_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_n, spm_rw;
    logic [31:0] spm_wr_data, spm_rd_data;
    logic        bus_req_n, bus_grnt_n;
    logic [29:0] bus_addr;
    logic        bus_as_n, bus_rw;
    logic [31:0] bus_wr_data, bus_rd_data;
    logic        bus_rdy_n;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    modport_if dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .busy(busy),
        .cpu_addr(cpu_addr), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .spm_addr(spm_addr), .spm_as_n(spm_as_n), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
        .bus_req_n(bus_req_n), .bus_grnt_n(bus_grnt_n), .bus_addr(bus_addr),
        .bus_as_n(bus_as_n), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_n(bus_rdy_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit to_spm(input logic [29:0] a);
        return a[29:27] == 3'd1;
    endfunction

    // Transaction-level model: one outstanding bus access, a grant flag, a
    // one-cycle strobe marker and a "result held during stall" flag.
    bit          m_act  = 1'b0;
    bit          m_gnt  = 1'b0;
    bit          m_stb  = 1'b0;
    bit          m_held = 1'b0;
    logic [29:0] m_addr = 30'h0;
    logic        m_rw   = 1'b1;
    logic [31:0] m_wd   = 32'h0;
    logic [31:0] m_buf  = 32'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0; m_gnt <= 1'b0; m_stb <= 1'b0; m_held <= 1'b0;
            m_addr <= 30'h0; m_rw <= 1'b1; m_wd <= 32'h0; m_buf <= 32'h0;
        end else if (m_held) begin
            if (!stall) m_held <= 1'b0;
        end else if (!m_act) begin
            if (!cpu_as_n && !flush && !to_spm(cpu_addr)) begin
                m_act <= 1'b1; m_addr <= cpu_addr; m_rw <= cpu_rw; m_wd <= cpu_wr_data;
            end
        end else if (!m_gnt) begin
            if (!bus_grnt_n) begin
                m_gnt <= 1'b1; m_stb <= 1'b1;
            end
        end else begin
            m_stb <= 1'b0;
            if (!bus_rdy_n) begin
                m_act <= 1'b0; m_gnt <= 1'b0; m_held <= stall;
                if (m_rw) m_buf <= bus_rd_data;
            end
        end
    end

    logic [31:0] e_rd;
    logic        e_busy, e_spm_as_n, e_valid;

    always @(negedge clk) begin
        if (chk_en) begin
            e_rd = 32'h0; e_busy = 1'b0; e_spm_as_n = 1'b1;
            e_valid = !cpu_as_n && !flush;
            if (m_held) begin
                e_rd = cpu_rw ? m_buf : 32'h0;
            end else if (!m_act) begin
                if (e_valid && to_spm(cpu_addr) && !stall) begin
                    e_spm_as_n = 1'b0;
                    e_rd = cpu_rw ? spm_rd_data : 32'h0;
                end
                e_busy = e_valid && !to_spm(cpu_addr);
            end else if (!m_gnt) begin
                e_busy = 1'b1;
            end else begin
                e_busy = bus_rdy_n;
                e_rd = (!bus_rdy_n && cpu_rw) ? bus_rd_data : 32'h0;
            end
            chk("busy", {31'h0, busy}, {31'h0, e_busy});
            chk("cpu_rd_data", cpu_rd_data, e_rd);
            chk("spm_as_n", {31'h0, spm_as_n}, {31'h0, e_spm_as_n});
            chk("spm_addr", {2'b00, spm_addr}, {2'b00, cpu_addr});
            chk("spm_rw", {31'h0, spm_rw}, {31'h0, cpu_rw});
            chk("spm_wr_data", spm_wr_data, cpu_wr_data);
            chk("bus_req_n", {31'h0, bus_req_n}, {31'h0, !m_act});
            chk("bus_as_n", {31'h0, bus_as_n}, {31'h0, !m_stb});
            chk("bus_addr", {2'b00, bus_addr}, m_act ? {2'b00, m_addr} : 32'h0);
            chk("bus_rw", {31'h0, bus_rw}, {31'h0, m_act ? m_rw : 1'b1});
            chk("bus_wr_data", bus_wr_data, m_act ? m_wd : 32'h0);
        end
    end

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic go();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        stall = 1'b0; flush = 1'b0; cpu_addr = 30'h0; cpu_as_n = 1'b1; cpu_rw = 1'b1;
        cpu_wr_data = 32'h0; spm_rd_data = 32'h0; bus_grnt_n = 1'b1;
        bus_rd_data = 32'h0; bus_rdy_n = 1'b1;
        #2 rst = 1'b0;
        go(); go();
        rst = 1'b1;
        chk_en = 1'b1;

        // reset state
        settle();
        chk("rst bus_req_n", {31'h0, bus_req_n}, 32'h1);
        chk("rst bus_as_n", {31'h0, bus_as_n}, 32'h1);
        chk("rst bus_addr", {2'b00, bus_addr}, 32'h0);
        chk("rst bus_rw", {31'h0, bus_rw}, 32'h1);
        chk("rst busy", {31'h0, busy}, 32'h0);
        go();

        // SPM read, then the same access under stall
        cpu_addr = 30'h0800_0123; cpu_as_n = 1'b0; cpu_rw = 1'b1; spm_rd_data = 32'hCAFE0001;
        settle();
        chk("spm spm_as_n", {31'h0, spm_as_n}, 32'h0);
        chk("spm cpu_rd_data", cpu_rd_data, 32'hCAFE0001);
        chk("spm busy", {31'h0, busy}, 32'h0);
        go();
        chk("spm bus_req_n", {31'h0, bus_req_n}, 32'h1);
        stall = 1'b1;
        settle();
        chk("spm stall spm_as_n", {31'h0, spm_as_n}, 32'h1);
        chk("spm stall cpu_rd_data", cpu_rd_data, 32'h0);
        go();

        // bus read: grant after 2 REQ cycles, ready one cycle after the strobe
        stall = 1'b0; cpu_addr = 30'h0000_0456; bus_rd_data = 32'h12345678;
        settle(); chk("brd idle busy", {31'h0, busy}, 32'h1);
        go();
        settle();
        chk("brd req busy", {31'h0, busy}, 32'h1);
        chk("brd bus_addr", {2'b00, bus_addr}, 32'h0000_0456);
        go();
        bus_grnt_n = 1'b0;
        go();
        settle();
        chk("brd strobe", {31'h0, bus_as_n}, 32'h0);
        chk("brd acc busy", {31'h0, busy}, 32'h1);
        go();
        bus_rdy_n = 1'b0;
        settle();
        chk("brd strobe end", {31'h0, bus_as_n}, 32'h1);
        chk("brd rd_data", cpu_rd_data, 32'h12345678);
        chk("brd rdy busy", {31'h0, busy}, 32'h0);
        go();
        cpu_as_n = 1'b1; bus_rdy_n = 1'b1; bus_grnt_n = 1'b1;
        settle();
        chk("brd done req_n", {31'h0, bus_req_n}, 32'h1);
        chk("brd done addr", {2'b00, bus_addr}, 32'h0);
        go();

        // bus write with immediate grant and ready
        cpu_addr = 30'h1000_0789; cpu_as_n = 1'b0; cpu_rw = 1'b0; cpu_wr_data = 32'hA5A5A5A5;
        go();
        bus_grnt_n = 1'b0;
        settle();
        chk("bwr wr_data", bus_wr_data, 32'hA5A5A5A5);
        chk("bwr rw", {31'h0, bus_rw}, 32'h0);
        chk("bwr req_n", {31'h0, bus_req_n}, 32'h0);
        go();
        bus_rdy_n = 1'b0;
        settle(); chk("bwr rd_data", cpu_rd_data, 32'h0);
        go();
        cpu_as_n = 1'b1; bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; cpu_rw = 1'b1;
        go();

        // bus read completing under stall: data held from the buffer
        cpu_addr = 30'h0000_0456; cpu_as_n = 1'b0; bus_grnt_n = 1'b0; bus_rd_data = 32'hDEADBEEF;
        go(); go();
        bus_rdy_n = 1'b0; stall = 1'b1;
        go();
        bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; bus_rd_data = 32'h0; cpu_as_n = 1'b1;
        settle();
        chk("stall rd_buf", cpu_rd_data, 32'hDEADBEEF);
        chk("stall busy", {31'h0, busy}, 32'h0);
        go();
        stall = 1'b0;
        settle(); chk("stall release rd", cpu_rd_data, 32'hDEADBEEF);
        go();
        settle(); chk("stall idle rd", cpu_rd_data, 32'h0);
        go();

        // flushed request is ignored
        cpu_addr = 30'h0000_0456; cpu_as_n = 1'b0; flush = 1'b1;
        settle(); chk("flush busy", {31'h0, busy}, 32'h0);
        go();
        chk("flush req_n", {31'h0, bus_req_n}, 32'h1);
        flush = 1'b0;

        // flush in REQ is ignored; reset in ACCESS aborts immediately
        go();
        flush = 1'b1; bus_grnt_n = 1'b0;
        go();
        settle(); chk("rstacc strobe", {31'h0, bus_as_n}, 32'h0);
        go();
        cpu_as_n = 1'b1; flush = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rstacc req_n", {31'h0, bus_req_n}, 32'h1);
        chk("rstacc as_n", {31'h0, bus_as_n}, 32'h1);
        chk("rstacc busy", {31'h0, busy}, 32'h0);
        go();
        rst = 1'b1; bus_grnt_n = 1'b1;
        go(); go();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/modport_if.md
Name: modport_if

Overview:
- Memory-access bus interface unit for one CPU pipeline stage (IF or MEM).
- Routes each CPU access either to the local scratch-pad memory (SPM) with zero wait states, or to the shared system bus.
- For the system bus it runs a request/grant/access/ready handshake and holds the pipeline busy until the access completes.
- Holds read data across pipeline stalls.

Parameters:
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width.
- SIDX_W, 3, slave-index width, taken from the top SIDX_W bits of the address.
- SPM_IDX, 1, slave index that selects the SPM; every other index goes to the bus.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall (active high).
- flush  in  1  pipeline flush (active high).
- busy  out  1  access in progress; pipeline must stall (active high).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_as_n  in  1  CPU address strobe (active low).
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_wr_data  in  DATA_W  CPU write data.
- cpu_rd_data  out  DATA_W  read data returned to the CPU.
- spm_addr  out  ADDR_W  SPM address.
- spm_as_n  out  1  SPM strobe (active low).
- spm_rw  out  1  SPM read/write.
- spm_wr_data  out  DATA_W  SPM write data.
- spm_rd_data  in  DATA_W  SPM read data.
- bus_req_n  out  1  bus request (active low).
- bus_grnt_n  in  1  bus grant (active low).
- bus_addr  out  ADDR_W  bus address.
- bus_as_n  out  1  bus strobe (active low).
- bus_rw  out  1  bus read/write.
- bus_wr_data  out  DATA_W  bus write data.
- bus_rd_data  in  DATA_W  bus read data.
- bus_rdy_n  in  1  bus ready (active low).

Behaviour:
- Slave index: sidx = cpu_addr[ADDR_W-1 -: SIDX_W].
- spm_addr, spm_rw and spm_wr_data are continuous copies of the matching CPU signals.
- A valid request is cpu_as_n=0 and flush=0.
- States: IDLE, REQ, ACCESS, STALL.
- Reset: all of the following are registered.
  - state=IDLE.
  - bus_req_n=1, bus_as_n=1.
  - bus_addr=0, bus_rw=1 (read), bus_wr_data=0.
  - Internal rd_buf=0.
- Combinational outputs: defaults are cpu_rd_data=0, spm_as_n=1, busy=0, overridden per state as follows.
  - IDLE, valid request, sidx==SPM_IDX, stall=0: spm_as_n=0; if cpu_rw=1, cpu_rd_data=spm_rd_data. The SPM returns data in the same cycle.
  - IDLE, valid request, sidx!=SPM_IDX: busy=1.
  - REQ: busy=1.
  - ACCESS: if bus_rdy_n=0, busy=0 and cpu_rd_data=bus_rd_data when cpu_rw=1; otherwise busy=1.
  - STALL: cpu_rd_data=rd_buf when cpu_rw=1; busy=0.
- Sequential transitions, on the rising clk edge:
  - IDLE -> REQ on a valid request with sidx!=SPM_IDX. Same edge: bus_req_n<=0, bus_addr<=cpu_addr, bus_rw<=cpu_rw, bus_wr_data<=cpu_wr_data.
  - SPM accesses stay in IDLE.
  - REQ -> ACCESS when bus_grnt_n=0; bus_as_n<=0. Otherwise stay in REQ.
  - ACCESS: bus_as_n<=1 every cycle, so the strobe is exactly one cycle wide.
  - ACCESS with bus_rdy_n=0:
    - bus_req_n<=1, bus_addr<=0, bus_rw<=1, bus_wr_data<=0.
    - If the registered bus_rw=1, rd_buf<=bus_rd_data.
    - Next state is STALL if stall=1, else IDLE.
  - ACCESS without ready: stay in ACCESS; request and address are held.
  - STALL -> IDLE when stall=0.
- Flush is honoured only in IDLE. Once in REQ or ACCESS, the access completes regardless of flush.
- An asynchronous reset in any state returns the unit to IDLE at once with the reset values above; any outstanding bus request is dropped.
- Minimum bus access is 3 cycles: IDLE, REQ, ACCESS with immediate grant and ready.

Test Plan:
- SPM read: sidx=1, cpu_as_n=0, cpu_rw=1, spm_rd_data=32'hCAFE0001 -> spm_as_n=0 and cpu_rd_data=32'hCAFE0001 in the same cycle, busy=0, bus_req_n stays 1.
- SPM access with stall=1 -> spm_as_n=1, cpu_rd_data=0.
- Bus read: cpu_addr with sidx=0, grant after 2 cycles, ready 1 cycle after bus_as_n, bus_rd_data=32'h12345678.
  - busy=1 through REQ and ACCESS.
  - bus_as_n low for exactly 1 cycle.
  - cpu_rd_data=32'h12345678 when bus_rdy_n=0.
  - Returns to IDLE with bus_req_n=1 and bus_addr=0.
- Bus write: cpu_rw=0, cpu_wr_data=32'hA5A5A5A5 -> bus_wr_data=32'hA5A5A5A5 and bus_rw=0 while bus_req_n=0; cpu_rd_data=0 throughout.
- Bus read completing while stall=1 -> enters STALL; cpu_rd_data=rd_buf=bus_rd_data while stalled; IDLE one cycle after stall drops.
- Request with flush=1 -> no state change, busy=0; reset asserted in ACCESS -> IDLE, bus_req_n=1, bus_as_n=1 immediately.
